i2c_bit_sequencer: RTL
======================

// Module: i2c_bit_sequencer
// PURPOSE
// - Sequences SCL/SDA open-drain drives for one I2C bit-level command at a time (START, STOP, WRITE bit, READ bit).
// - Sits between the byte/transaction controller (upstream) and the SCL/SDA I/O pads. Uses its own quarter-period timebase.
// - Handles slave clock stretching, detects arbitration loss and tracks bus ownership.
// PARAMETERS
// - DIV_DEFAULT     25      quarter-period count used when i_quarter_div < 2 (100 kHz SCL at 10 MHz)
// - TIMEOUT_CYCLES  250000  stretch-timeout limit in i_sys_clk cycles (25 ms at 10 MHz); used only with I2C_SCL_TIMEOUT_EN
// PORTS
// - i_sys_clk      in   1   system clock
// - i_rst_n        in   1   async active-low reset
// - i_enable       in   1   block enable; low aborts and releases both lines
// - i_cmd_valid    in   1   command valid
// - o_cmd_ready    out  1   command ready
// - i_cmd          in   2   00 START, 01 STOP, 10 WRITE, 11 READ
// - i_cmd_bit      in   1   data bit for WRITE
// - i_quarter_div  in   16  sys clocks per quarter SCL period; latched on accept
// - o_rsp_valid    out  1   one-cycle completion pulse
// - o_rsp_bit      out  1   SDA sampled in phase 2 (READ data / WRITE readback)
// - o_arb_lost     out  1   sticky arbitration-lost flag
// - o_timeout      out  1   sticky stretch-timeout flag
// - o_busy         out  1   bus owned (after START, before STOP)
// - i_scl_in       in   1   SCL pad level, already 2-flop synchronised upstream
// - i_sda_in       in   1   SDA pad level, already 2-flop synchronised upstream
// - o_scl_oe       out  1   1 = drive SCL low, 0 = release
// - o_sda_oe       out  1   1 = drive SDA low, 0 = release
// BEHAVIOUR
// - Reset: every output is 0. FSM is in IDLE; counters are 0.
// - FSM states: IDLE, PH0, PH1, PH2, PH3. Command and divider are latched on the accept edge (i_cmd_valid & o_cmd_ready).
// - o_cmd_ready = IDLE & i_enable & !o_arb_lost & !o_timeout.
// - Phase timing: latched div < 2 is replaced by DIV_DEFAULT. The quarter counter runs 0..div-1. The tick at div-1 advances the phase.
// - PH0 drive is valid the cycle after accept. PH3 tick -> IDLE. o_rsp_valid goes high the next cycle.
// - Accept-to-rsp_valid latency: 4*div+1 cycles, absent stretching.
// - Drive table (scl_oe,sda_oe) for PH0..PH3:
//   - START: 00,00,01,11.
//   - STOP: 11,01,01,00.
//   - WRITE b: scl 1,0,0,1; sda ~b in all phases.
//   - READ: scl 1,0,0,1; sda 0 in all phases.
// - Sampling: i_sda_in is sampled on the PH2 tick and presented on o_rsp_bit with o_rsp_valid. o_rsp_bit holds until the next completion.
// - Stretch: the quarter counter holds while o_scl_oe==0 && i_scl_in==0. Phase timing resumes from the held count.
// - Arbitration: on the PH2 tick of WRITE b=1 with i_sda_in==0:
//   - set o_arb_lost, release both lines, clear o_busy, go to IDLE;
//   - pulse o_rsp_valid with o_rsp_bit=0.
// - o_busy: set on START completion; cleared on STOP completion, arbitration loss, timeout or disable.
// - i_enable low, at any time: next cycle both oe=0, IDLE, counters 0, o_busy/o_arb_lost/o_timeout cleared, no rsp pulse.
// - Reset mid-command: immediate release of both lines. No response is generated.
// - i_cmd_valid while not ready is ignored. No command queueing.
// CONFIGURATION
// - I2C_SCL_TIMEOUT_EN defined:
//   - a 32-bit counter increments on every stretch-hold cycle and clears when the hold ends.
//   - At TIMEOUT_CYCLES: set o_timeout, release both lines, clear o_busy, go to IDLE, pulse o_rsp_valid with o_rsp_bit=0.
// - I2C_SCL_TIMEOUT_EN undefined: o_timeout tied 0; stretching is unbounded.
// STRUCTURE
// - Shared package i2c_seq_pkg holds:
//   - command encodings CMD_START/CMD_STOP/CMD_WRITE/CMD_READ;
//   - FSM state encodings;
//   - DIV_MIN=2.
// - One sub-module, i2c_quarter_tick: divider counter with load, hold (stretch) and tick output. The FSM and drive table stay in the top.
// TESTING
// - div=4, START, lines idle high -> (scl_oe,sda_oe) = 00,00,01,11 for 4 cycles each; o_rsp_valid 17 cycles after accept; o_busy=1.
// - WRITE 0, then WRITE 1, SDA pulled up -> sda_oe=1 then 0; o_rsp_bit 0 then 1; scl_oe pattern 1,0,0,1 each time.
// - READ, i_sda_in=0, i_scl_in held low 20 cycles in PH1 -> o_rsp_bit=0; o_rsp_valid 20 cycles later than nominal.
// - WRITE 1 with i_sda_in forced 0 -> o_arb_lost=1, both oe=0, o_busy=0, o_cmd_ready=0 until i_enable toggles.
// - i_enable dropped in PH2 of READ -> next cycle both oe=0, o_busy=0, no o_rsp_valid.
// - I2C_SCL_TIMEOUT_EN, TIMEOUT_CYCLES=50, i_scl_in stuck low -> o_timeout=1 after 50 hold cycles, lines released, rsp bit 0.

Source files
------------

// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C bit sequencer: command encodings, FSM
// state encodings and the smallest usable quarter-period divider.
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'b00,
    CMD_STOP  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_READ  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    PH0,
    PH1,
    PH2,
    PH3
  } state_e;

  localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period timebase for the I2C bit sequencer.
// Counts 0..i_div-1 and pulses o_tick on the last count. The count freezes
// while i_hold is high (slave clock stretching) and resumes from where it
// stopped.
// Ports:
//   i_sys_clk, i_rst_n  clock, async active-low reset
//   i_clr               force the count to 0 (idle / disabled)
//   i_hold              freeze the count, suppress the tick
//   i_div               quarter-period length in clocks (>= 2)
//   o_tick              high in the last cycle of a quarter period
module i2c_quarter_tick (
  input  logic        i_sys_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic        i_hold,
  input  logic [15:0] i_div,
  output logic        o_tick
);

  logic [15:0] cnt_q, cnt_d;
  logic        at_end;

  always_comb begin
    at_end = (cnt_q == i_div - 16'd1);
    cnt_d  = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (!i_hold) begin
      cnt_d = at_end ? '0 : cnt_q + 16'd1;
    end
    o_tick = !i_clr && !i_hold && at_end;
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_bit_sequencer.sv
// I2C bit sequencer: drives SCL/SDA open-drain enables for one bit-level
// command (START, STOP, WRITE bit, READ bit) in four quarter-period phases,
// honours slave clock stretching, detects arbitration loss and tracks bus
// ownership.
// Optional feature macro: I2C_SCL_TIMEOUT_EN adds a stretch timeout
// (TIMEOUT_CYCLES clocks); without it o_timeout is tied low.
// Ports:
//   i_sys_clk, i_rst_n            clock, async active-low reset
//   i_enable                      low aborts and releases both lines
//   i_cmd_valid/o_cmd_ready       command handshake
//   i_cmd, i_cmd_bit              command and WRITE data bit
//   i_quarter_div                 clocks per quarter period, latched on accept
//   o_rsp_valid, o_rsp_bit        completion pulse and sampled SDA
//   o_arb_lost, o_timeout         sticky error flags
//   o_busy                        bus owned (between START and STOP)
//   i_scl_in, i_sda_in            synchronised pad levels
//   o_scl_oe, o_sda_oe            1 = pull line low
module i2c_bit_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] DIV_DEFAULT = 16'd25
`ifdef I2C_SCL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 250000
`endif
) (
  input  logic        i_sys_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [1:0]  i_cmd,
  input  logic        i_cmd_bit,
  input  logic [15:0] i_quarter_div,
  output logic        o_rsp_valid,
  output logic        o_rsp_bit,
  output logic        o_arb_lost,
  output logic        o_timeout,
  output logic        o_busy,
  input  logic        i_scl_in,
  input  logic        i_sda_in,
  output logic        o_scl_oe,
  output logic        o_sda_oe
);

  state_e      state_q, state_d;
  cmd_e        cmd_q, cmd_d;
  logic        bit_q, bit_d;
  logic [15:0] div_q, div_d;
  logic        samp_q, samp_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_bit_q, rsp_bit_d;
  logic        arb_q, arb_d;
  logic        busy_q, busy_d;
  logic        to_q, to_d;
  logic        tick, hold, accept, timeout_evt;

  // Drive table, derived from state so IDLE always releases both lines.
  always_comb begin
    o_scl_oe = 1'b0;
    o_sda_oe = 1'b0;
    if (state_q != IDLE) begin
      unique case (cmd_q)
        CMD_START: begin
          o_scl_oe = (state_q == PH3);
          o_sda_oe = (state_q == PH2) || (state_q == PH3);
        end
        CMD_STOP: begin
          o_scl_oe = (state_q == PH0);
          o_sda_oe = (state_q != PH3);
        end
        CMD_WRITE: begin
          o_scl_oe = (state_q == PH0) || (state_q == PH3);
          o_sda_oe = !bit_q;
        end
        default: begin
          o_scl_oe = (state_q == PH0) || (state_q == PH3);
          o_sda_oe = 1'b0;
        end
      endcase
    end
  end

  // A released SCL still held low by the bus means a slave is stretching.
  assign hold = (state_q != IDLE) && !o_scl_oe && !i_scl_in;

  i2c_quarter_tick u_tick (
    .i_sys_clk (i_sys_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     ((state_q == IDLE) || !i_enable),
    .i_hold    (hold),
    .i_div     (div_q),
    .o_tick    (tick)
  );

`ifdef I2C_SCL_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d    = (i_enable && hold) ? to_cnt_q + 32'd1 : '0;
    timeout_evt = i_enable && hold && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end

  assign o_timeout = to_q;
`else
  assign timeout_evt = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  assign o_cmd_ready = (state_q == IDLE) && i_enable && !arb_q && !o_timeout;
  assign accept      = i_cmd_valid && o_cmd_ready;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    bit_d       = bit_q;
    div_d       = div_q;
    samp_d      = samp_q;
    rsp_valid_d = 1'b0;
    rsp_bit_d   = rsp_bit_q;
    arb_d       = arb_q;
    busy_d      = busy_q;
    to_d        = to_q;

    if (!i_enable) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      arb_d   = 1'b0;
      to_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cmd_d   = cmd_e'(i_cmd);
            bit_d   = i_cmd_bit;
            div_d   = (i_quarter_div < 16'(DIV_MIN)) ? DIV_DEFAULT : i_quarter_div;
            state_d = PH0;
          end
        end
        PH0: if (tick) state_d = PH1;
        PH1: if (tick) state_d = PH2;
        PH2: begin
          if (tick) begin
            samp_d = i_sda_in;
            // We released SDA for a 1 but someone else holds it low.
            if (cmd_q == CMD_WRITE && bit_q && !i_sda_in) begin
              arb_d       = 1'b1;
              busy_d      = 1'b0;
              state_d     = IDLE;
              rsp_valid_d = 1'b1;
              rsp_bit_d   = 1'b0;
            end else begin
              state_d = PH3;
            end
          end
        end
        PH3: begin
          if (tick) begin
            state_d     = IDLE;
            rsp_valid_d = 1'b1;
            rsp_bit_d   = samp_q;
            if (cmd_q == CMD_START) busy_d = 1'b1;
            if (cmd_q == CMD_STOP)  busy_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase

      if (timeout_evt) begin
        to_d        = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_bit_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= CMD_START;
      bit_q       <= 1'b0;
      div_q       <= '0;
      samp_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_bit_q   <= 1'b0;
      arb_q       <= 1'b0;
      busy_q      <= 1'b0;
      to_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      samp_q      <= samp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_bit_q   <= rsp_bit_d;
      arb_q       <= arb_d;
      busy_q      <= busy_d;
      to_q        <= to_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_bit   = rsp_bit_q;
  assign o_arb_lost  = arb_q;
  assign o_busy      = busy_q;

endmodule
